// File: rtl/acc_stream_fetch.sv
// acc_stream_fetch: streams a word-aligned block from data memory to the accelerator over valid/ready.
//   clk, reset (async, active-high)
//   start/startaddr/datasize : transfer request (IDLE only), word count in datasize[SIZE_W-1:0]
//   mem_re/mem_addr/mem_rdata: data memory read port, read data one cycle after mem_re
//   out_valid/out_data/out_last/out_ready : output stream
//   busy : RUN or DRAIN, done : one-cycle end-of-transfer pulse
//   Optional ACC_FETCH_ABORT_EN adds abort (input) and aborted (output, pulses with done).
module acc_stream_fetch #(
  parameter int SIZE_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] startaddr,
  input  logic [31:0] datasize,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef ACC_FETCH_ABORT_EN
  ,
  input  logic        abort,
  output logic        aborted
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t              r_state, w_next;
  logic [31:0]         r_addr;
  logic [SIZE_W-1:0]   r_rem, r_sent, r_size;
  logic                r_inflight, r_rp, r_wp;
  logic [1:0]          r_count;
  logic [31:0]         r_buf [2];
  logic [SIZE_W-1:0]   w_size;
  logic                w_pop, w_room, w_abort;
  logic                w_unused;
  assign w_unused  = ^{startaddr[1:0], datasize[31:SIZE_W]};
  assign w_size    = datasize[SIZE_W-1:0];
  assign mem_addr  = r_addr;
  assign out_valid = r_count != 2'd0;
  assign out_data  = r_buf[r_rp];
  assign out_last  = out_valid & (r_sent == r_size - SIZE_W'(1));
  assign w_pop     = out_valid & out_ready;
  // Buffered plus in-flight words after this cycle's pop must leave room for one more return.
  assign w_room    = ({1'b0, r_count} + {2'b0, r_inflight}) < (3'(BUF_DEPTH) + {2'b0, w_pop});
`ifdef ACC_FETCH_ABORT_EN
  assign w_abort   = abort & (r_state == RUN | r_state == DRAIN);
`else
  assign w_abort   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    mem_re = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: w_next = start ? (w_size != '0 ? RUN : DONE) : IDLE;
      RUN: begin
        busy   = 1'b1;
        mem_re = (r_rem != '0) & w_room & ~w_abort;
        w_next = (mem_re && r_rem == SIZE_W'(1)) ? DRAIN : RUN;
      end
      // Finish in the cycle the last buffered word leaves, so done follows the final pop directly.
      DRAIN: begin
        busy   = 1'b1;
        w_next = (!r_inflight && r_count == {1'b0, w_pop}) ? DONE : DRAIN;
      end
      default: begin
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
    if (w_abort) w_next = DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_sent     <= '0;
      r_size     <= '0;
      r_inflight <= 1'b0;
      r_rp       <= 1'b0;
      r_wp       <= 1'b0;
      r_count    <= 2'd0;
      r_buf      <= '{default: '0};
    end else begin
      if (r_state == IDLE && start) begin
        r_addr <= {startaddr[31:2], 2'b00};
        r_rem  <= w_size;
        r_size <= w_size;
        r_sent <= '0;
      end
      if (mem_re) begin
        r_addr <= r_addr + 32'd4;
        r_rem  <= r_rem - SIZE_W'(1);
      end
      if (w_pop) r_sent <= r_sent + SIZE_W'(1);
      if (w_abort) begin
        r_inflight <= 1'b0;
        r_rp       <= 1'b0;
        r_wp       <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        r_inflight <= mem_re;
        if (r_inflight) begin
          r_buf[r_wp] <= mem_rdata;
          r_wp        <= ~r_wp;
        end
        if (w_pop) r_rp <= ~r_rp;
        r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
    end
`ifdef ACC_FETCH_ABORT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) aborted <= 1'b0;
    else aborted <= w_abort;
`endif
endmodule

// File: tb/tb_acc_stream_fetch.sv
// tb_acc_stream_fetch: directed self-checking bench for acc_stream_fetch.
module tb_acc_stream_fetch;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [31:0] startaddr = '0, datasize = '0, mem_rdata = '0;
  logic mem_re, out_valid, out_last, busy, done;
  logic [31:0] mem_addr, out_data;
`ifdef ACC_FETCH_ABORT_EN
  logic abort = 1'b0, aborted;
`endif
  int pass_n = 0, tot_n = 0;
  logic [31:0] re_q[$], w_q[$];
  int nlast, last_idx, ndone, done_c, nbusy, busy_first, busy_last, re_first_c, re_last_c;
  int valid_first_c, max_occ, n_ab, ab_c, valid_after_ab;
  int stall_after = -1, stall_len = 0, restart_c = 0, abort_after = -1;

  acc_stream_fetch dut (
    .clk(clk), .reset(reset), .start(start), .startaddr(startaddr), .datasize(datasize),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef ACC_FETCH_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory returns data exactly one cycle after mem_re, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_re ? pat(mem_addr) : 32'hDEAD_BEEF;

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] s);
    @(negedge clk);
    startaddr = a;
    datasize  = s;
    start     = 1'b1;
  endtask

  // Runs n cycles after the start edge, recording what the DUT does.
  task automatic collect(input int n);
    int issued = 0, popped = 0, stalls = 0, abort_at = 0;
    re_q.delete(); w_q.delete();
    nlast = 0; last_idx = -1; ndone = 0; done_c = 0; nbusy = 0; busy_first = 0; busy_last = 0;
    re_first_c = 0; re_last_c = 0; valid_first_c = 0; max_occ = 0; n_ab = 0; ab_c = 0; valid_after_ab = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      if (c == restart_c) begin
        startaddr = 32'h500;
        datasize  = 9;
      end
      out_ready = !(popped == stall_after && stalls < stall_len);
      if (!out_ready) stalls++;
`ifdef ACC_FETCH_ABORT_EN
      abort = (abort_at == 0 && popped == abort_after);
      if (abort) begin
        abort_at  = c;
        out_ready = 1'b0;
      end
`endif
      #1;
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (mem_re) begin
        re_q.push_back(mem_addr);
        if (re_first_c == 0) re_first_c = c;
        re_last_c = c;
        issued++;
      end
      if (out_valid && valid_first_c == 0) valid_first_c = c;
      if (out_valid && out_ready) begin
        w_q.push_back(out_data);
        if (out_last) begin
          nlast++;
          last_idx = w_q.size() - 1;
        end
        popped++;
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
      if (busy) begin
        nbusy++;
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
`ifdef ACC_FETCH_ABORT_EN
      if (aborted) begin
        n_ab++;
        ab_c = c;
      end
      if (abort_at != 0 && c > abort_at && out_valid) valid_after_ab++;
`endif
    end
    start = 1'b0;
    out_ready = 1'b1;
`ifdef ACC_FETCH_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset;
    #3;
    tot_n++; if ({mem_re, out_valid, out_last, busy, done} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {mem_re, out_valid, out_last, busy, done}); else pass_n++;
    tot_n++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else pass_n++;
    tot_n++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h want 0", out_data); else pass_n++;
`ifdef ACC_FETCH_ABORT_EN
    tot_n++; if (aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", aborted); else pass_n++;
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    start_xfer(32'h100, 4);
    collect(10);
    tot_n++; if (re_q.size() != 4) $display("FAIL basic_nreads: got %0d want 4", re_q.size()); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      tot_n++; if (re_q[i] !== 32'h100 + 4 * i) $display("FAIL basic_addr%0d: got %h want %h", i, re_q[i], 32'h100 + 4 * i); else pass_n++;
      tot_n++; if (w_q[i] !== pat(32'h100 + 4 * i)) $display("FAIL basic_word%0d: got %h want %h", i, w_q[i], pat(32'h100 + 4 * i)); else pass_n++;
    end
    tot_n++; if (re_first_c != 1 || re_last_c != 4) $display("FAIL basic_re_cycles: got %0d..%0d want 1..4", re_first_c, re_last_c); else pass_n++;
    tot_n++; if (valid_first_c != 3) $display("FAIL basic_first_valid: got %0d want 3", valid_first_c); else pass_n++;
    tot_n++; if (nlast != 1 || last_idx != 3) $display("FAIL basic_last: got n=%0d idx=%0d want n=1 idx=3", nlast, last_idx); else pass_n++;
    tot_n++; if (ndone != 1 || done_c != 7) $display("FAIL basic_done: got n=%0d c=%0d want n=1 c=7", ndone, done_c); else pass_n++;
    tot_n++; if (busy_first != 1 || busy_last != 6 || nbusy != 6) $display("FAIL basic_busy: got %0d..%0d n=%0d want 1..6 n=6", busy_first, busy_last, nbusy); else pass_n++;
    tot_n++; if (w_q.size() != 4) $display("FAIL basic_nwords: got %0d want 4", w_q.size()); else pass_n++;
  endtask

  task automatic test_zero;
    start_xfer(32'h40, 32'h0001_0000);
    collect(4);
    tot_n++; if (ndone != 1 || done_c != 1) $display("FAIL zero_done: got n=%0d c=%0d want n=1 c=1", ndone, done_c); else pass_n++;
    tot_n++; if (re_q.size() != 0) $display("FAIL zero_reads: got %0d want 0", re_q.size()); else pass_n++;
    tot_n++; if (nbusy != 0) $display("FAIL zero_busy: got %0d want 0", nbusy); else pass_n++;
  endtask

  task automatic test_backpressure;
    stall_after = 2;
    stall_len = 5;
    start_xfer(32'h200, 8);
    collect(30);
    stall_after = -1;
    tot_n++; if (max_occ > 2) $display("FAIL bp_occupancy: got %0d want <=2", max_occ); else pass_n++;
    tot_n++; if (re_q.size() != 8 || w_q.size() != 8) $display("FAIL bp_counts: got r=%0d w=%0d want 8/8", re_q.size(), w_q.size()); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      tot_n++; if (w_q[i] !== pat(32'h200 + 4 * i)) $display("FAIL bp_word%0d: got %h want %h", i, w_q[i], pat(32'h200 + 4 * i)); else pass_n++;
    end
    tot_n++; if (nlast != 1 || last_idx != 7) $display("FAIL bp_last: got n=%0d idx=%0d want n=1 idx=7", nlast, last_idx); else pass_n++;
    tot_n++; if (ndone != 1) $display("FAIL bp_done: got %0d want 1", ndone); else pass_n++;
  endtask

  task automatic test_align_wrap;
    start_xfer(32'h103, 2);
    collect(8);
    tot_n++; if (re_q.size() != 2 || re_q[0] !== 32'h100 || re_q[1] !== 32'h104) $display("FAIL align_addr: got n=%0d %h %h want 100 104", re_q.size(), re_q[0], re_q[1]); else pass_n++;
    tot_n++; if (w_q.size() != 2 || w_q[0] !== pat(32'h100)) $display("FAIL align_word: got %h want %h", w_q[0], pat(32'h100)); else pass_n++;
    start_xfer(32'hFFFF_FFFC, 2);
    collect(8);
    tot_n++; if (re_q.size() != 2 || re_q[0] !== 32'hFFFF_FFFC || re_q[1] !== 32'h0) $display("FAIL wrap_addr: got n=%0d %h %h want fffffffc 0", re_q.size(), re_q[0], re_q[1]); else pass_n++;
    tot_n++; if (w_q.size() != 2 || w_q[1] !== pat(32'h0)) $display("FAIL wrap_word: got %h want %h", w_q[1], pat(32'h0)); else pass_n++;
    tot_n++; if (ndone != 1 || nlast != 1) $display("FAIL wrap_end: got done=%0d last=%0d want 1/1", ndone, nlast); else pass_n++;
  endtask

  task automatic test_restart_ignored;
    restart_c = 2;
    start_xfer(32'h300, 4);
    collect(14);
    restart_c = 0;
    tot_n++; if (re_q.size() != 4 || re_q[3] !== 32'h30C) $display("FAIL restart_reads: got n=%0d last=%h want 4 30c", re_q.size(), re_q[3]); else pass_n++;
    tot_n++; if (w_q.size() != 4 || ndone != 1) $display("FAIL restart_end: got w=%0d done=%0d want 4/1", w_q.size(), ndone); else pass_n++;
  endtask

  task automatic test_midreset;
    int nd = 0;
    start_xfer(32'h400, 6);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tot_n++; if ({mem_re, out_valid, out_last, busy, done} !== 5'b0) $display("FAIL midrst_ctl: got %b want 00000", {mem_re, out_valid, out_last, busy, done}); else pass_n++;
    tot_n++; if (mem_addr !== 32'h0 || out_data !== 32'h0) $display("FAIL midrst_data: got %h %h want 0 0", mem_addr, out_data); else pass_n++;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done || busy) nd++;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done || busy) nd++;
    end
    tot_n++; if (nd != 0) $display("FAIL midrst_nodone: got %0d active cycles want 0", nd); else pass_n++;
    start_xfer(32'h600, 3);
    collect(10);
    tot_n++; if (re_q.size() != 3 || re_q[0] !== 32'h600 || re_q[2] !== 32'h608) $display("FAIL midrst_new_reads: got n=%0d %h want 3 600", re_q.size(), re_q[0]); else pass_n++;
    tot_n++; if (w_q.size() != 3 || w_q[2] !== pat(32'h608) || ndone != 1) $display("FAIL midrst_new_words: got n=%0d %h done=%0d want 3 %h 1", w_q.size(), w_q[2], ndone, pat(32'h608)); else pass_n++;
  endtask

`ifdef ACC_FETCH_ABORT_EN
  task automatic test_abort;
    abort_after = 3;
    start_xfer(32'h700, 10);
    collect(12);
    abort_after = -1;
    tot_n++; if (re_q.size() != 5 || re_last_c != 5) $display("FAIL abort_reads: got n=%0d last_c=%0d want 5/5", re_q.size(), re_last_c); else pass_n++;
    tot_n++; if (w_q.size() != 3) $display("FAIL abort_words: got %0d want 3", w_q.size()); else pass_n++;
    tot_n++; if (ndone != 1 || done_c != 7) $display("FAIL abort_done: got n=%0d c=%0d want 1/7", ndone, done_c); else pass_n++;
    tot_n++; if (n_ab != 1 || ab_c != 7) $display("FAIL abort_flag: got n=%0d c=%0d want 1/7", n_ab, ab_c); else pass_n++;
    tot_n++; if (valid_after_ab != 0) $display("FAIL abort_valid: got %0d want 0", valid_after_ab); else pass_n++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_align_wrap();
    test_restart_ignored();
    test_midreset();
`ifdef ACC_FETCH_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/acc_stream_fetch.md
Name: acc_stream_fetch

Overview:
- Accelerator-side fetch engine sitting directly downstream of the core datapath's special load-word registers.
- Consumes the latched start address and data size, plus a start pulse from control.
- Reads the data memory word by word and streams the words to the accelerator over a valid/ready interface.
- Holds `busy` high while active; `busy` drives the core's bypass/stall (accbypass) path.

Parameters:
- SIZE_W, 16, number of low bits of datasize used as the word count (max 2^SIZE_W-1 words).
- BUF_DEPTH, 2, output skid buffer depth in words (fixed at 2; other values unsupported).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; honoured only in IDLE.
- startaddr  input  32  byte start address; bits [1:0] ignored (forced word aligned).
- datasize  input  32  transfer length in words; only bits [SIZE_W-1:0] used.
- mem_re  output  1  data memory read enable.
- mem_addr  output  32  data memory byte address, word aligned.
- mem_rdata  input  32  read data, valid exactly one cycle after mem_re.
- out_valid  output  1  stream word available.
- out_data  output  32  stream word.
- out_last  output  1  qualifies the final word of the transfer.
- out_ready  input  1  accelerator accepts the word when out_valid & out_ready.
- busy  output  1  transfer in progress (RUN or DRAIN).
- done  output  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0.
  - FSM in IDLE.
  - Buffer empty, in-flight flag cleared, counters 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start with size = datasize[SIZE_W-1:0] != 0: latch addr = {startaddr[31:2],2'b00}, remaining = size, sent = 0; go to RUN.
  - On start with size = 0: go to DONE; no memory reads are issued.
  - start outside IDLE is ignored.
- RUN read issue:
  - Let inflight = mem_re from the previous cycle, count = buffer occupancy, pop = out_valid & out_ready.
  - mem_re = (remaining != 0) & (count + inflight - pop < 2).
  - mem_addr = addr, a combinational function of current state.
  - Each issue: addr += 4 (wraps modulo 2^32), remaining -= 1.
  - When remaining reaches 0, go to DRAIN.
- Read return: mem_rdata is written into the FIFO buffer at the end of the cycle after mem_re. A write and a pop in the same cycle are both allowed.
- Output stage:
  - out_valid = buffer non-empty; out_data = buffer head.
  - out_last = out_valid & (sent == size-1).
  - sent increments on each pop.
- Throughput and latency:
  - With out_ready held high, 1 word/cycle sustained.
  - First mem_re in the cycle after start.
  - First out_valid 2 cycles after the first mem_re.
- DRAIN: go to DONE once the buffer is empty, inflight = 0 and no pop is pending.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy is 1 in RUN and DRAIN, and 0 in IDLE and DONE.
- Backpressure: the buffer never overflows; no word is lost or duplicated; order is preserved.
- Reset mid-transfer: immediate return to IDLE; buffer and in-flight data discarded; no done pulse.

Optional Feature:
- Macro: ACC_FETCH_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort in RUN or DRAIN:
    - mem_re deasserts the same cycle.
    - Buffer flushed and the in-flight return dropped.
    - Next state DONE, with done = 1 and aborted = 1 in that cycle.
  - abort in IDLE or DONE has no effect.
  - aborted resets to 0.
- Undefined: neither port exists; transfers always run to completion.

Test Plan:
- startaddr=0x100, datasize=4, out_ready=1 -> mem_re on 4 consecutive cycles at 0x100/104/108/10C; out_data in order; out_last only on the 4th word; done one cycle after the last pop; busy high from cycle 1 until done.
- datasize=0 with start -> done pulse in the next cycle; mem_re never asserted; busy stays 0.
- datasize=8 with out_ready low for 5 cycles after the 2nd word -> count+inflight never exceeds 2; all 8 words delivered in order with no loss or duplicates.
- startaddr=0x103 and startaddr=0xFFFFFFFC with datasize=2 -> first reads at 0x100 and 0xFFFFFFFC respectively; the second read of the 0xFFFFFFFC case wraps to 0x00000000.
- start pulsed again during RUN -> ignored; reset asserted mid-RUN -> all outputs 0 immediately; no done; a new start afterwards works normally.
- With ACC_FETCH_ABORT_EN defined, abort after the 3rd of 10 words -> no further mem_re; out_valid drops; done=aborted=1 for one cycle.
